// File: rtl/tf_round_sequencer.sv
// Iterates a registered Threefish-1024 round core NUM_ROUNDS times over one latched block.
// Optional feature: define TF_SEQ_ABORT_EN to add the abort input.
module tf_round_sequencer #(
    parameter int WIDTH      = 1024,
    parameter int NUM_ROUNDS = 80,
    parameter int CORE_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] block_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] block_out,
    output logic [7:0]       blocks_done,
    output logic [WIDTH-1:0] core_pt,
    output logic [6:0]       core_round,
    output logic             core_valid,
`ifdef TF_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] core_ct
);

    localparam int             CNT_W    = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [6:0]     LAST_RND = 7'(NUM_ROUNDS - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CORE_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   data;
    logic [6:0]         round;
    logic [CNT_W-1:0]   wait_cnt;
    logic               abort_req;
    logic               accept;
    logic               capture;
    logic               last_round;

`ifdef TF_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign last_round = (round == LAST_RND);
    // The round state reg doubles as the core operand, so it only moves on edges into ISSUE.
    assign core_pt    = data;
    assign core_round = round;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        capture    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        core_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                busy       = 1'b1;
                core_valid = 1'b1;
                state_nx   = abort_req ? IDLE : WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (abort_req) begin
                    state_nx = IDLE;
                end else if (wait_cnt == '0) begin
                    capture  = 1'b1;
                    state_nx = last_round ? DONE : ISSUE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data        <= '0;
            round       <= '0;
            wait_cnt    <= '0;
            block_out   <= '0;
            blocks_done <= '0;
        end else begin
            if (accept) begin
                data  <= block_in;
                round <= '0;
            end
            if (state == ISSUE) begin
                wait_cnt <= CNT_INIT;
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
            // Final result bypasses the round reg so core_pt stays put through DONE.
            if (capture) begin
                if (last_round) begin
                    block_out <= core_ct;
                end else begin
                    data  <= core_ct;
                    round <= round + 7'd1;
                end
            end
            if (state == DONE) begin
                blocks_done <= blocks_done + 8'd1;
            end
        end
    end

endmodule
